// File: rtl/target_generator_if.sv
// target_generator_if: game-control inputs and target/score outputs of the target generator
interface target_generator_if #(
    parameter int SCORE_WIDTH = 8
);
    logic [1:0]             MSM_STATE;
    logic                   TARGET_REACHED;
    logic [7:0]             TARGET_ADDR_X;
    logic [6:0]             TARGET_ADDR_Y;
    logic                   TARGET_VALID;
    logic                   NEW_TARGET;
    logic [SCORE_WIDTH-1:0] SCORE;
    logic                   WIN;
    modport master (
        input  MSM_STATE, TARGET_REACHED,
        output TARGET_ADDR_X, TARGET_ADDR_Y, TARGET_VALID, NEW_TARGET, SCORE, WIN
    );
    modport slave (
        output MSM_STATE, TARGET_REACHED,
        input  TARGET_ADDR_X, TARGET_ADDR_Y, TARGET_VALID, NEW_TARGET, SCORE, WIN
    );
endinterface

// File: rtl/target_generator.sv
// target_generator: places the snake's target pseudo-randomly on a 160x120 grid and keeps score
module target_generator #(
    parameter int         MAX_X       = 160,
    parameter int         MAX_Y       = 120,
    parameter int         INIT_X      = 40,
    parameter int         INIT_Y      = 30,
    parameter logic [7:0] SEED_X      = 8'hB5,
    parameter logic [6:0] SEED_Y      = 7'h5A,
    parameter int         MAX_RETRY   = 16,
    parameter int         SCORE_WIDTH = 8,
    parameter int         WIN_SCORE   = 10
) (
    input  logic               CLK,
    input  logic               RESET,
    target_generator_if.master bus
);
    localparam int RW = $clog2(MAX_RETRY);
    localparam logic [7:0] MX = 8'(MAX_X);
    localparam logic [6:0] MY = 7'(MAX_Y);
    localparam logic [7:0] IX = 8'(INIT_X);
    localparam logic [6:0] IY = 7'(INIT_Y);
    localparam logic [RW-1:0] RL = RW'(MAX_RETRY - 1);
    localparam logic [SCORE_WIDTH-1:0] WS = SCORE_WIDTH'(WIN_SCORE);

    typedef enum logic [1:0] {IDLE, ARMED, GEN, WAIT_CLEAR} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             lfsr_x_q, lfsr_x_d, x_q, x_d, fold_x;
    logic [6:0]             lfsr_y_q, lfsr_y_d, y_q, y_d, fold_y;
    logic [RW-1:0]          retry_q, retry_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic                   valid_q, valid_d, new_q, new_d, win_q, win_d, reached_q;
    logic                   hit, ok;

    // Next-state: free-running LFSRs, game FSM, target draw with fold fallback
    always_comb begin
        lfsr_x_d = {lfsr_x_q[6:0], lfsr_x_q[7] ^ lfsr_x_q[5] ^ lfsr_x_q[4] ^ lfsr_x_q[3]};
        lfsr_y_d = {lfsr_y_q[5:0], lfsr_y_q[6] ^ lfsr_y_q[5]};
        hit      = bus.TARGET_REACHED & ~reached_q;
        fold_x   = (lfsr_x_q >= MX) ? lfsr_x_q - MX : lfsr_x_q;
        fold_y   = (lfsr_y_q >= MY) ? lfsr_y_q - MY : lfsr_y_q;
        ok       = lfsr_x_q < MX && lfsr_y_q < MY && {lfsr_x_q, lfsr_y_q} != {x_q, y_q};
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        valid_d  = valid_q;
        new_d    = 1'b0;
        score_d  = score_q;
        retry_d  = retry_q;
        win_d    = score_q >= WS;
        if (bus.MSM_STATE == 2'd0) begin
            state_d = IDLE;
            x_d     = IX;
            y_d     = IY;
            valid_d = 1'b0;
            score_d = '0;
            retry_d = '0;
        end else if (bus.MSM_STATE == 2'd1) begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                    valid_d = 1'b1;
                end
                ARMED: if (hit) begin
                    state_d = GEN;
                    valid_d = 1'b0;
                    retry_d = '0;
                    score_d = score_q + SCORE_WIDTH'(~&score_q);
                end
                GEN: if (ok || retry_q == RL) begin
                    x_d     = fold_x;
                    y_d     = fold_y;
                    new_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = WAIT_CLEAR;
                end else begin
                    retry_d = retry_q + RW'(1);
                end
                WAIT_CLEAR: if (!bus.TARGET_REACHED) state_d = ARMED;
            endcase
        end
    end

    // State registers; reset restores seeds and the idle target
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            lfsr_x_q  <= SEED_X;
            lfsr_y_q  <= SEED_Y;
            x_q       <= IX;
            y_q       <= IY;
            retry_q   <= '0;
            score_q   <= '0;
            valid_q   <= 1'b0;
            new_q     <= 1'b0;
            win_q     <= 1'b0;
            reached_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_x_q  <= lfsr_x_d;
            lfsr_y_q  <= lfsr_y_d;
            x_q       <= x_d;
            y_q       <= y_d;
            retry_q   <= retry_d;
            score_q   <= score_d;
            valid_q   <= valid_d;
            new_q     <= new_d;
            win_q     <= win_d;
            reached_q <= bus.TARGET_REACHED;
        end
    end

    assign bus.TARGET_ADDR_X = x_q;
    assign bus.TARGET_ADDR_Y = y_q;
    assign bus.TARGET_VALID  = valid_q;
    assign bus.NEW_TARGET    = new_q;
    assign bus.SCORE         = score_q;
    assign bus.WIN           = win_q;
endmodule

// File: tb/tb_target_generator.sv
// tb_target_generator: directed game scenarios checked against a cycle-level game-rule model
module tb_target_generator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    bit model_on = 1'b0;

    target_generator_if #(.SCORE_WIDTH(8)) bus ();
    target_generator dut (.CLK(clk), .RESET(rst), .bus(bus));

    always #5 clk = ~clk;

    // LFSR sequences straight from the polynomials
    int lx[255];
    int ly[127];
    logic [7:0] v8;
    logic [6:0] v7;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game-rule model: phase 0 idle, 1 armed, 2 drawing, 3 waiting for the head to leave
    int m_x, m_y, m_valid, m_new, m_score, m_win, m_phase, m_tries, m_prev, m_n;
    int cx, cy;
    always @(posedge clk) begin
        if (rst) begin
            m_x = 40; m_y = 30; m_valid = 0; m_new = 0; m_score = 0; m_win = 0;
            m_phase = 0; m_tries = 0; m_prev = 0; m_n = 0;
        end else begin
            cx = lx[m_n % 255];
            cy = ly[m_n % 127];
            m_win = (m_score >= 10) ? 1 : 0;
            m_new = 0;
            if (bus.MSM_STATE == 2'd0) begin
                m_phase = 0; m_x = 40; m_y = 30; m_valid = 0; m_score = 0;
            end else if (bus.MSM_STATE == 2'd1) begin
                if (m_phase == 0) begin
                    m_phase = 1; m_valid = 1;
                end else if (m_phase == 1) begin
                    if (bus.TARGET_REACHED && !m_prev) begin
                        m_phase = 2; m_tries = 0; m_valid = 0;
                        m_score = (m_score == 255) ? 255 : m_score + 1;
                    end
                end else if (m_phase == 2) begin
                    m_tries++;
                    if (cx < 160 && cy < 120 && !(cx == m_x && cy == m_y)) begin
                        m_x = cx; m_y = cy; m_new = 1; m_valid = 1; m_phase = 3;
                    end else if (m_tries == 16) begin
                        m_x = cx % 160; m_y = cy % 120; m_new = 1; m_valid = 1; m_phase = 3;
                    end
                end else if (!bus.TARGET_REACHED) begin
                    m_phase = 1;
                end
            end
            m_prev = bus.TARGET_REACHED ? 1 : 0;
            m_n++;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (model_on) begin
            chk("x", bus.TARGET_ADDR_X, m_x);
            chk("y", bus.TARGET_ADDR_Y, m_y);
            chk("valid", bus.TARGET_VALID, m_valid);
            chk("new_target", bus.NEW_TARGET, m_new);
            chk("score", bus.SCORE, m_score);
            chk("win", bus.WIN, m_win);
            if (bus.TARGET_VALID) begin
                chk("x_in_range", bus.TARGET_ADDR_X < 160, 1);
                chk("y_in_range", bus.TARGET_ADDR_Y < 120, 1);
            end
        end
    end

    // One target hit with the head held for 'hold' cycles; returns cycles until NEW_TARGET
    task automatic hit(input int hold, output int lat);
        lat = 0;
        repeat (2) @(negedge clk);
        bus.TARGET_REACHED = 1'b1;
        for (int k = 1; k <= hold + 40; k++) begin
            @(negedge clk);
            if (bus.NEW_TARGET && lat == 0) lat = k;
            if (k >= hold) bus.TARGET_REACHED = 1'b0;
            if (k >= hold && lat != 0) break;
        end
        bus.TARGET_REACHED = 1'b0;
        chk("new_target_latency_ok", (lat >= 2 && lat <= 17) ? 1 : 0, 1);
    endtask

    int lat;
    int sx, sy, ss;
    bit found;
    initial begin
        v8 = 8'hB5;
        v7 = 7'h5A;
        for (int i = 0; i < 255; i++) begin
            lx[i] = v8;
            v8 = {v8[6:0], v8[7] ^ v8[5] ^ v8[4] ^ v8[3]};
        end
        for (int i = 0; i < 127; i++) begin
            ly[i] = v7;
            v7 = {v7[5:0], v7[6] ^ v7[5]};
        end
        chk("lfsr_x_step1", lx[1], 8'h6B);
        chk("lfsr_y_step1", ly[1], 7'h35);
        chk("lfsr_x_period", v8, 8'hB5);
        chk("lfsr_y_period", v7, 7'h5A);

        bus.MSM_STATE = 2'd0;
        bus.TARGET_REACHED = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_on = 1'b1;
        chk("reset_x", bus.TARGET_ADDR_X, 40);
        chk("reset_y", bus.TARGET_ADDR_Y, 30);
        chk("reset_valid", bus.TARGET_VALID, 0);
        chk("reset_score", bus.SCORE, 0);
        chk("reset_win", bus.WIN, 0);
        @(negedge clk);
        chk("idle_valid", bus.TARGET_VALID, 0);
        bus.MSM_STATE = 2'd1;
        @(negedge clk);
        chk("armed_valid", bus.TARGET_VALID, 1);

        hit(1, lat);
        chk("first_hit_score", bus.SCORE, 1);
        chk("first_target_moved", (bus.TARGET_ADDR_X != 40 || bus.TARGET_ADDR_Y != 30) ? 1 : 0, 1);

        hit(50, lat);
        chk("held_hit_score", bus.SCORE, 2);

        for (int i = 0; i < 1000; i++) hit(1, lat);
        @(negedge clk);
        chk("saturated_score", bus.SCORE, 255);
        chk("win_set", bus.WIN, 1);

        repeat (2) @(negedge clk);
        bus.TARGET_REACHED = 1'b1;
        @(negedge clk);
        bus.TARGET_REACHED = 1'b0;
        bus.MSM_STATE = 2'd2;
        sx = bus.TARGET_ADDR_X;
        sy = bus.TARGET_ADDR_Y;
        ss = bus.SCORE;
        repeat (5) @(negedge clk);
        chk("frozen_valid", bus.TARGET_VALID, 0);
        chk("frozen_x", bus.TARGET_ADDR_X, sx);
        chk("frozen_y", bus.TARGET_ADDR_Y, sy);
        chk("frozen_score", bus.SCORE, ss);
        bus.MSM_STATE = 2'd1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = bus.NEW_TARGET;
        end
        chk("resume_new_target", found, 1);
        bus.MSM_STATE = 2'd0;
        @(negedge clk);
        chk("abort_x", bus.TARGET_ADDR_X, 40);
        chk("abort_y", bus.TARGET_ADDR_Y, 30);
        chk("abort_score", bus.SCORE, 0);

        bus.MSM_STATE = 2'd1;
        repeat (3) @(negedge clk);
        bus.TARGET_REACHED = 1'b1;
        @(negedge clk);
        bus.TARGET_REACHED = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midgen_reset_x", bus.TARGET_ADDR_X, 40);
        chk("midgen_reset_y", bus.TARGET_ADDR_Y, 30);
        chk("midgen_reset_valid", bus.TARGET_VALID, 0);
        chk("midgen_reset_new", bus.NEW_TARGET, 0);
        chk("midgen_reset_score", bus.SCORE, 0);
        for (int i = 0; i < 5; i++) hit(1, lat);
        chk("post_reset_score", bus.SCORE, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
